// File: rtl/psola_pkg.sv
// psola_pkg: shared defaults, FSM state encoding and sample saturation helper for psola_playback.
package psola_pkg;

   localparam int WINDOW_SIZE_DEF = 2048;
   localparam int FRAC_BITS_DEF   = 10;
   localparam int OUT_WIDTH_DEF   = 16;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT1, WAIT2} state_t;

   // Drops fraction bits and clamps into the signed range of an out-wide sample.
   function automatic logic signed [31:0] sat_shift(input logic signed [31:0] v, input int frac, input int width);
      logic signed [31:0] s, hi, lo;
      s  = v >>> frac;
      hi = (32'sd1 <<< (width - 1)) - 32'sd1;
      lo = -hi - 32'sd1;
      return (s > hi) ? hi : (s < lo) ? lo : s;
   endfunction

endpackage

// File: rtl/pipeline.sv
// pipeline: STAGES-deep register delay line with asynchronous active-low clear.
module pipeline #(
   parameter int WIDTH  = 1,
   parameter int STAGES = 2
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] regs [STAGES];

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         for (int i = 0; i < STAGES; i++) regs[i] <= '0;
      end else begin
         regs[0] <= d;
         for (int i = 1; i < STAGES; i++) regs[i] <= regs[i-1];
      end
   end

   assign q = regs[STAGES-1];

endmodule

// File: rtl/psola_playback.sv
// psola_playback: plays a finished PSOLA output frame from the overlap-add buffer, one sample per tick.
// Define PSOLA_PLAYBACK_CLEAR_EN to zero each buffer word as it is played.
module psola_playback
   import psola_pkg::*;
#(
   parameter int WINDOW_SIZE = WINDOW_SIZE_DEF,
   parameter int FRAC_BITS   = FRAC_BITS_DEF,
   parameter int OUT_WIDTH   = OUT_WIDTH_DEF,
   localparam int LOG_WINDOW_SIZE = $clog2(WINDOW_SIZE)
) (
   input  logic                         clk_in,
   input  logic                         rst_in,
   input  logic [11:0]                  window_len_in,
   input  logic                         window_len_valid_in,
   input  logic                         sample_tick_in,
   output logic [LOG_WINDOW_SIZE:0]     read_addr_out,
   input  logic signed [31:0]           read_val_in,
   output logic [LOG_WINDOW_SIZE:0]     clear_addr_out,
   output logic                         clear_valid_out,
   output logic signed [OUT_WIDTH-1:0]  sample_out,
   output logic                         sample_valid_out,
   output logic                         busy_out,
   output logic                         frame_done_out,
   output logic                         underrun_out
);

   localparam int AW = LOG_WINDOW_SIZE + 1;

   state_t        state;
   logic [AW-1:0] idx, act_len, pend_len, new_len;
   logic          act_v, pend_v, iss_v, iss_u, load, last, out_v, out_u;

   assign load    = window_len_valid_in && (window_len_in != 12'd0);
   assign new_len = (32'(window_len_in) > 32'(WINDOW_SIZE)) ? AW'(WINDOW_SIZE) : AW'(window_len_in);
   assign last    = (idx + AW'(1)) == act_len;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state          <= IDLE;
         idx            <= '0;
         act_len        <= '0;
         pend_len       <= '0;
         act_v          <= 1'b0;
         pend_v         <= 1'b0;
         iss_v          <= 1'b0;
         iss_u          <= 1'b0;
         read_addr_out  <= '0;
         busy_out       <= 1'b0;
         frame_done_out <= 1'b0;
      end else begin
         iss_v          <= 1'b0;
         iss_u          <= 1'b0;
         frame_done_out <= 1'b0;
         case (state)
            IDLE: if (sample_tick_in) begin
               iss_v         <= 1'b1;
               iss_u         <= !act_v;
               read_addr_out <= idx;
               if (act_v) state <= ISSUE;
            end
            ISSUE: state <= WAIT1;
            WAIT1: state <= WAIT2;
            default: begin
               state <= IDLE;
               idx   <= last ? '0 : idx + AW'(1);
               if (last) begin
                  frame_done_out <= 1'b1;
                  if (pend_v) begin
                     act_len <= pend_len;
                     pend_v  <= 1'b0;
                  end else begin
                     act_v    <= 1'b0;
                     busy_out <= 1'b0;
                  end
               end
            end
         endcase
         // A frame finishing this cycle with nothing pending frees the active slot for the new length.
         if (load) begin
            if (!act_v || (state == WAIT2 && last && !pend_v)) begin
               act_len  <= new_len;
               act_v    <= 1'b1;
               busy_out <= 1'b1;
            end else begin
               pend_len <= new_len;
               pend_v   <= 1'b1;
            end
         end
      end
   end

`ifdef PSOLA_PLAYBACK_CLEAR_EN
   logic [AW+1:0] pipe_q;
   pipeline #(.WIDTH(AW + 2), .STAGES(2)) u_pipe (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .d      ({iss_v, iss_u, read_addr_out}),
      .q      (pipe_q)
   );
   assign out_v = pipe_q[AW+1];
   assign out_u = pipe_q[AW];

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         clear_valid_out <= 1'b0;
         clear_addr_out  <= '0;
      end else begin
         clear_valid_out <= out_v && !out_u;
         clear_addr_out  <= (out_v && !out_u) ? pipe_q[AW-1:0] : '0;
      end
   end
`else
   logic [1:0] pipe_q;
   pipeline #(.WIDTH(2), .STAGES(2)) u_pipe (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .d      ({iss_v, iss_u}),
      .q      (pipe_q)
   );
   assign out_v           = pipe_q[1];
   assign out_u           = pipe_q[0];
   assign clear_valid_out = 1'b0;
   assign clear_addr_out  = '0;
`endif

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         sample_out       <= '0;
         sample_valid_out <= 1'b0;
         underrun_out     <= 1'b0;
      end else begin
         sample_valid_out <= out_v;
         underrun_out     <= out_v && out_u;
         sample_out       <= (out_v && !out_u) ? OUT_WIDTH'(sat_shift(read_val_in, FRAC_BITS, OUT_WIDTH)) : '0;
      end
   end

endmodule

// File: tb/tb_psola_playback.sv
// tb_psola_playback: scoreboard bench for psola_playback with a 2-cycle-latency buffer model.
module tb_psola_playback;

   logic               clk_in = 1'b0, rst_in = 1'b1;
   logic [11:0]        window_len_in = '0;
   logic               window_len_valid_in = 1'b0, sample_tick_in = 1'b0;
   logic [11:0]        read_addr_out, clear_addr_out;
   logic signed [31:0] read_val_in;
   logic               clear_valid_out, sample_valid_out, busy_out, frame_done_out, underrun_out;
   logic signed [15:0] sample_out;

   psola_playback dut (
      .clk_in              (clk_in),
      .rst_in              (rst_in),
      .window_len_in       (window_len_in),
      .window_len_valid_in (window_len_valid_in),
      .sample_tick_in      (sample_tick_in),
      .read_addr_out       (read_addr_out),
      .read_val_in         (read_val_in),
      .clear_addr_out      (clear_addr_out),
      .clear_valid_out     (clear_valid_out),
      .sample_out          (sample_out),
      .sample_valid_out    (sample_valid_out),
      .busy_out            (busy_out),
      .frame_done_out      (frame_done_out),
      .underrun_out        (underrun_out)
   );

   always #5 clk_in = ~clk_in;

   logic signed [31:0] mem [4096];
   logic signed [31:0] r1, r2;
   always @(posedge clk_in) begin
      r1 <= mem[read_addr_out];
      r2 <= r1;
   end
   assign read_val_in = r2;

   int cyc = 0;
   always @(posedge clk_in) cyc <= cyc + 1;

   int checks = 0, errors = 0;
   typedef struct {
      logic signed [15:0] s;
      logic               done;
      logic               und;
      logic [11:0]        addr;
      int                 cyc;
   } exp_t;
   exp_t sb[$];
   exp_t e;
   logic watch_busy = 1'b0, busy_dropped = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   always @(negedge clk_in) begin
      if (rst_in) begin
         if (watch_busy && !busy_out) busy_dropped = 1'b1;
         if (sample_valid_out) begin
            if (sb.size() == 0) check("spurious_valid", 32'(sample_valid_out), 0);
            else begin
               e = sb.pop_front();
               check("sample", sample_out, e.s);
               check("latency", cyc, e.cyc);
               check("frame_done", 32'(frame_done_out), 32'(e.done));
               check("underrun", 32'(underrun_out), 32'(e.und));
`ifdef PSOLA_PLAYBACK_CLEAR_EN
               check("clear_valid", 32'(clear_valid_out), 32'(!e.und));
               if (!e.und) check("clear_addr", 32'(clear_addr_out), 32'(e.addr));
`else
               check("clear_valid", 32'(clear_valid_out), 0);
               check("clear_addr", 32'(clear_addr_out), 0);
`endif
            end
         end else if (frame_done_out || underrun_out || clear_valid_out)
            check("stray_pulse", {29'd0, frame_done_out, underrun_out, clear_valid_out}, 0);
      end
   end

   task automatic do_tick(input logic push, input logic signed [15:0] s, input logic done,
                          input logic und, input logic [11:0] addr, input int gap);
      @(posedge clk_in);
      #1 sample_tick_in = 1'b1;
      if (push) sb.push_back('{s, done, und, addr, cyc + 4});
      @(posedge clk_in);
      #1 sample_tick_in = 1'b0;
      repeat (gap) @(posedge clk_in);
   endtask

   task automatic load(input logic [11:0] len);
      @(posedge clk_in);
      #1 window_len_in = len;
      window_len_valid_in = 1'b1;
      @(posedge clk_in);
      #1 window_len_valid_in = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 30 && sb.size() != 0; i++) @(posedge clk_in);
      check("drain", sb.size(), 0);
      repeat (3) @(posedge clk_in);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: bench did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = '0;
      #2 rst_in = 1'b0;
      repeat (2) @(posedge clk_in);
      #1;
      check("rst_sample", sample_out, 0);
      check("rst_valid", 32'(sample_valid_out), 0);
      check("rst_busy", 32'(busy_out), 0);
      check("rst_done", 32'(frame_done_out), 0);
      check("rst_underrun", 32'(underrun_out), 0);
      check("rst_clear_valid", 32'(clear_valid_out), 0);
      check("rst_clear_addr", 32'(clear_addr_out), 0);
      check("rst_read_addr", 32'(read_addr_out), 0);
      rst_in = 1'b1;

      do_tick(1, 16'sd0, 0, 1, 0, 3);
      drain();
      load(12'd0);
      check("zero_len_busy", 32'(busy_out), 0);
      do_tick(1, 16'sd0, 0, 1, 0, 3);
      drain();

      mem[0] = 1024; mem[1] = 2048; mem[2] = -1024; mem[3] = 0;
      load(12'd4);
      check("load_busy", 32'(busy_out), 1);
      do_tick(1, 16'sd1, 0, 0, 0, 8);
      do_tick(1, 16'sd2, 0, 0, 1, 8);
      do_tick(1, -16'sd1, 0, 0, 2, 8);
      do_tick(1, 16'sd0, 1, 0, 3, 8);
      drain();
      check("frame_end_busy", 32'(busy_out), 0);

      mem[0] = 32'h7fffffff; mem[1] = 32'h80000000;
      load(12'd2);
      do_tick(1, 16'sh7fff, 0, 0, 0, 3);
      do_tick(1, -16'sd32768, 1, 0, 1, 3);
      drain();

      mem[0] = 3072; mem[1] = 4096; mem[2] = 5120;
      load(12'd3);
      watch_busy = 1'b1;
      do_tick(1, 16'sd3, 0, 0, 0, 3);
      load(12'd2);
      check("pending_busy", 32'(busy_out), 1);
      do_tick(1, 16'sd4, 0, 0, 1, 3);
      do_tick(1, 16'sd5, 1, 0, 2, 3);
      do_tick(1, 16'sd3, 0, 0, 0, 3);
      repeat (2) @(posedge clk_in);
      watch_busy = 1'b0;
      check("busy_hold", 32'(busy_dropped), 0);
      do_tick(1, 16'sd4, 1, 0, 1, 3);
      drain();
      check("promote_end_busy", 32'(busy_out), 0);

      load(12'd2);
      @(posedge clk_in);
      #1 sample_tick_in = 1'b1;
      sb.push_back('{16'sd3, 1'b0, 1'b0, 12'd0, cyc + 4});
      repeat (3) @(posedge clk_in);
      #1 sample_tick_in = 1'b0;
      repeat (4) @(posedge clk_in);
      do_tick(1, 16'sd4, 1, 0, 1, 3);
      drain();

      for (int i = 0; i < 2048; i++) mem[i] = (i - 1024) * 1024;
      load(12'd4000);
      check("clamp_busy", 32'(busy_out), 1);
      for (int i = 0; i < 2048; i++) do_tick(1, 16'(i - 1024), i == 2047, 0, 12'(i), 2);
      drain();
      check("clamp_end_busy", 32'(busy_out), 0);
      do_tick(1, 16'sd0, 0, 1, 0, 3);
      drain();

      mem[0] = 1024;
      load(12'd2);
      @(posedge clk_in);
      #1 sample_tick_in = 1'b1;
      @(posedge clk_in);
      #1 sample_tick_in = 1'b0;
      @(posedge clk_in);
      #1 check("pre_reset_busy", 32'(busy_out), 1);
      rst_in = 1'b0;
      #1;
      check("mid_rst_busy", 32'(busy_out), 0);
      check("mid_rst_valid", 32'(sample_valid_out), 0);
      check("mid_rst_read_addr", 32'(read_addr_out), 0);
      check("mid_rst_sample", sample_out, 0);
      repeat (2) @(posedge clk_in);
      #1 rst_in = 1'b1;
      repeat (10) @(posedge clk_in);
      do_tick(1, 16'sd0, 0, 1, 0, 3);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
